// File: rtl/mag_packet_serializer.sv
// Packs one magnetometer sample and its geiger window count into a 13-byte packet
// (10 data bytes LSB-first, 2 count bytes MSB-first, XOR checksum) over valid/ready.
module mag_packet_serializer #(
    parameter int GEIG_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_1MHZ,
    input  logic        RESET,
    input  logic [79:0] MAG_DATA,
    input  logic        GEIG_COUNTS,
    input  logic        SAMPLE_TICK,
    input  logic        BYTE_READY,
    output logic [7:0]  BYTE_OUT,
    output logic        BYTE_VALID,
    output logic        PKT_START,
    output logic        BUSY,
    output logic        OVERRUN
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2
    } state_t;

    state_t                  state_r;
    logic [SYNC_STAGES-1:0]  geig_sync_r;
    logic                    geig_dly_r;
    logic                    geig_edge_s;
    logic [GEIG_WIDTH-1:0]   geig_cnt_r;
    logic [GEIG_WIDTH-1:0]   geig_cnt_inc_s;
    logic                    tick_accept_s;
    logic                    xfer_s;
    logic [79:0]             shadow_r;
    logic [GEIG_WIDTH-1:0]   gcap_r;
    logic [3:0]              idx_r;
    logic [7:0]              csum_r;
    logic [7:0]              byte_out_r;
    logic                    byte_valid_r;
    logic                    pkt_start_r;
    logic                    busy_r;
    logic                    overrun_r;

    // Saturating increment so a flood of events pins the count instead of wrapping
    function automatic logic [GEIG_WIDTH-1:0] sat_inc(input logic [GEIG_WIDTH-1:0] value,
                                                      input logic                  inc);
        logic [GEIG_WIDTH-1:0] result;
        if (inc && (value != {GEIG_WIDTH{1'b1}})) begin
            result = value + {{(GEIG_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic logic [7:0] pkt_byte(input logic [3:0]            idx,
                                            input logic [79:0]           shadow,
                                            input logic [GEIG_WIDTH-1:0] gcap);
        logic [7:0] result;
        case (idx)
            4'd0:    result = shadow[7:0];
            4'd1:    result = shadow[15:8];
            4'd2:    result = shadow[23:16];
            4'd3:    result = shadow[31:24];
            4'd4:    result = shadow[39:32];
            4'd5:    result = shadow[47:40];
            4'd6:    result = shadow[55:48];
            4'd7:    result = shadow[63:56];
            4'd8:    result = shadow[71:64];
            4'd9:    result = shadow[79:72];
            4'd10:   result = gcap[15:8];
            4'd11:   result = gcap[7:0];
            default: result = 8'h00;
        endcase
        return result;
    endfunction

    // Edge detect, accepted-tick and handshake decode
    always_comb begin
        geig_edge_s    = geig_sync_r[SYNC_STAGES-1] ^ geig_dly_r;
        geig_cnt_inc_s = sat_inc(geig_cnt_r, geig_edge_s);
        tick_accept_s  = SAMPLE_TICK && (state_r == ST_IDLE);
        xfer_s         = byte_valid_r && BYTE_READY;
    end

    // Geiger synchroniser, edge delay flop and window counter
    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            geig_sync_r <= {SYNC_STAGES{1'b0}};
            geig_dly_r  <= 1'b0;
            geig_cnt_r  <= {GEIG_WIDTH{1'b0}};
        end else begin
            geig_sync_r <= {geig_sync_r[SYNC_STAGES-2:0], GEIG_COUNTS};
            geig_dly_r  <= geig_sync_r[SYNC_STAGES-1];
            // The edge seen in the tick cycle goes to the closing window via gcap
            if (tick_accept_s) begin
                geig_cnt_r <= {GEIG_WIDTH{1'b0}};
            end else begin
                geig_cnt_r <= geig_cnt_inc_s;
            end
        end
    end

    // Packet FSM with registered handshake outputs
    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            shadow_r     <= 80'h0;
            gcap_r       <= {GEIG_WIDTH{1'b0}};
            idx_r        <= 4'd0;
            csum_r       <= 8'h00;
            byte_out_r   <= 8'h00;
            byte_valid_r <= 1'b0;
            pkt_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (SAMPLE_TICK && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (tick_accept_s) begin
                        shadow_r     <= MAG_DATA;
                        gcap_r       <= geig_cnt_inc_s;
                        idx_r        <= 4'd0;
                        csum_r       <= 8'h00;
                        byte_out_r   <= MAG_DATA[7:0];
                        byte_valid_r <= 1'b1;
                        pkt_start_r  <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        csum_r      <= csum_r ^ byte_out_r;
                        pkt_start_r <= 1'b0;
                        idx_r       <= idx_r + 4'd1;
                        if (idx_r == 4'd11) begin
                            byte_out_r <= csum_r ^ byte_out_r;
                            state_r    <= ST_CSUM;
                        end else begin
                            byte_out_r <= pkt_byte(idx_r + 4'd1, shadow_r, gcap_r);
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer_s) begin
                        byte_out_r   <= 8'h00;
                        byte_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    byte_valid_r <= 1'b0;
                    pkt_start_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign BYTE_OUT   = byte_out_r;
    assign BYTE_VALID = byte_valid_r;
    assign PKT_START  = pkt_start_r;
    assign BUSY       = busy_r;
    assign OVERRUN    = overrun_r;

endmodule
